// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests instructions at Pc, holds each one until control
// issues a next-PC command, and latches a sticky fault if memory never acknowledges.

package opcodes;
   typedef enum logic [1:0] {
      PcWait = 2'd0,
      PcInc  = 2'd1,
      PcJmp  = 2'd2
   } PcSel_t;
endpackage

module fetch_unit #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  opcodes::PcSel_t        PcSel,
   input  logic [PC_WIDTH-1:0]    JmpAddr,
   output logic                   MemReq,
   output logic [PC_WIDTH-1:0]    MemAddr,
   input  logic                   MemAck,
   input  logic [INSTR_WIDTH-1:0] MemData,
   output logic [INSTR_WIDTH-1:0] Instr,
   output logic                   InstrValid,
   output logic [PC_WIDTH-1:0]    Pc,
   output logic                   Fault
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t                 r_state,  w_state_nxt;
   logic [PC_WIDTH-1:0]    r_pc,     w_pc_nxt;
   logic [INSTR_WIDTH-1:0] r_instr,  w_instr_nxt;
   logic                   r_valid,  w_valid_nxt;
   logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
   logic                   r_fault,  w_fault_nxt;

   // State and datapath registers; reset overrides everything, including a coincident MemAck.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_FETCH;
         r_pc    <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
         r_valid <= w_valid_nxt;
         r_cnt   <= w_cnt_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   // Next-state and memory-request logic.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_valid_nxt = r_valid;
      w_cnt_nxt   = r_cnt;
      w_fault_nxt = r_fault;
      MemReq      = 1'b0;
      MemAddr     = r_pc;
      case (r_state)
         S_FETCH: begin
            MemReq = 1'b1;
            if (MemAck) begin
               w_instr_nxt = MemData;
               w_valid_nxt = 1'b1;
               w_state_nxt = S_HOLD;
            end else if (r_cnt == CNT_LAST) begin
               // The ack-less cycle that would reach ACK_TIMEOUT trips the fault.
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               w_fault_nxt = 1'b1;
               w_state_nxt = S_FAULT;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_HOLD: begin
            case (PcSel)
               opcodes::PcInc: begin
                  w_pc_nxt    = r_pc + PC_WIDTH'(1);
                  w_valid_nxt = 1'b0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_FETCH;
               end
               opcodes::PcJmp: begin
                  w_pc_nxt    = JmpAddr;
                  w_valid_nxt = 1'b0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_FETCH;
               end
               default: begin
                  w_state_nxt = S_HOLD;
               end
            endcase
         end
         S_FAULT: begin
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b1;
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b1;
            w_state_nxt = S_FAULT;
         end
      endcase
   end

   assign Instr      = r_instr;
   assign InstrValid = r_valid;
   assign Pc         = r_pc;
   assign Fault      = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected post-edge outputs,
// a negedge monitor pops and compares them.

module tb_fetch_unit;

   logic            Clock = 1'b0;
   logic            Reset;
   opcodes::PcSel_t PcSel;
   logic [7:0]      JmpAddr;
   logic            MemReq;
   logic [7:0]      MemAddr;
   logic            MemAck;
   logic [15:0]     MemData;
   logic [15:0]     Instr;
   logic            InstrValid;
   logic [7:0]      Pc;
   logic            Fault;

   typedef struct {
      string       name;
      int          cyc;
      logic [34:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .ACK_TIMEOUT(15)) dut (
      .Clock(Clock), .Reset(Reset), .PcSel(PcSel), .JmpAddr(JmpAddr),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
      .Instr(Instr), .InstrValid(InstrValid), .Pc(Pc), .Fault(Fault)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   // Monitor: compares each expectation against the outputs after its edge.
   always @(negedge Clock) begin
      logic [34:0] act;
      exp_t        e;
      act = {MemReq, MemAddr, Instr, InstrValid, Pc, Fault};
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
         end else if (act !== e.vec) begin
            errors++;
            $display("FAIL %s: got req=%b addr=%h instr=%h v=%b pc=%h f=%b, want req=%b addr=%h instr=%h v=%b pc=%h f=%b",
                     e.name, act[34], act[33:26], act[25:10], act[9], act[8:1], act[0],
                     e.vec[34], e.vec[33:26], e.vec[25:10], e.vec[9], e.vec[8:1], e.vec[0]);
         end
      end else if (done && exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
         exp_q.delete();
      end
   end

   task automatic step(input string nm, input logic rst, input opcodes::PcSel_t sel,
                       input logic [7:0] jmp, input logic ack, input logic [15:0] data,
                       input logic e_req, input logic [7:0] e_addr, input logic [15:0] e_instr,
                       input logic e_v, input logic [7:0] e_pc, input logic e_f);
      exp_t e;
      Reset   = rst;
      PcSel   = sel;
      JmpAddr = jmp;
      MemAck  = ack;
      MemData = data;
      e.name  = nm;
      e.cyc   = cyc + 1;
      e.vec   = {e_req, e_addr, e_instr, e_v, e_pc, e_f};
      exp_q.push_back(e);
      @(posedge Clock);
      #1;
   endtask

   initial begin
      Reset   = 1'b1;
      PcSel   = opcodes::PcWait;
      JmpAddr = 8'h00;
      MemAck  = 1'b0;
      MemData = 16'h0000;
      @(posedge Clock);
      #1;
      step("reset", 1'b1, opcodes::PcWait, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      step("first_fetch", 1'b0, opcodes::PcWait, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h00, 16'h1234, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++)
         step("hold_wait", 1'b0, opcodes::PcWait, 8'h00, (i == 2) ? 1'b1 : 1'b0, 16'hDEAD,
              1'b0, 8'h00, 16'h1234, 1'b1, 8'h00, 1'b0);
      step("inc_to_1", 1'b0, opcodes::PcInc, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h01, 16'h1234, 1'b0, 8'h01, 1'b0);
      step("fetch_ign_sel", 1'b0, opcodes::PcJmp, 8'h99, 1'b0, 16'h0000, 1'b1, 8'h01, 16'h1234, 1'b0, 8'h01, 1'b0);
      step("fetch_beef", 1'b0, opcodes::PcWait, 8'h00, 1'b1, 16'hBEEF, 1'b0, 8'h01, 16'hBEEF, 1'b1, 8'h01, 1'b0);
      step("jmp_ff", 1'b0, opcodes::PcJmp, 8'hFF, 1'b0, 16'h0000, 1'b1, 8'hFF, 16'hBEEF, 1'b0, 8'hFF, 1'b0);
      step("fetch_0a0a", 1'b0, opcodes::PcWait, 8'h00, 1'b1, 16'h0A0A, 1'b0, 8'hFF, 16'h0A0A, 1'b1, 8'hFF, 1'b0);
      step("inc_wrap", 1'b0, opcodes::PcInc, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0A0A, 1'b0, 8'h00, 1'b0);
      step("fetch_5555", 1'b0, opcodes::PcWait, 8'h00, 1'b1, 16'h5555, 1'b0, 8'h00, 16'h5555, 1'b1, 8'h00, 1'b0);
      step("jmp_40", 1'b0, opcodes::PcJmp, 8'h40, 1'b0, 16'h0000, 1'b1, 8'h40, 16'h5555, 1'b0, 8'h40, 1'b0);
      for (int i = 0; i < 14; i++)
         step("late_ack_wait", 1'b0, opcodes::PcWait, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h40, 16'h5555, 1'b0, 8'h40, 1'b0);
      step("ack_on_15th", 1'b0, opcodes::PcWait, 8'h00, 1'b1, 16'h7777, 1'b0, 8'h40, 16'h7777, 1'b1, 8'h40, 1'b0);
      step("inc_to_41", 1'b0, opcodes::PcInc, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h41, 16'h7777, 1'b0, 8'h41, 1'b0);
      for (int i = 0; i < 14; i++)
         step("timeout_wait", 1'b0, opcodes::PcWait, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h41, 16'h7777, 1'b0, 8'h41, 1'b0);
      step("timeout_fault", 1'b0, opcodes::PcWait, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h41, 16'h7777, 1'b0, 8'h41, 1'b1);
      step("fault_ign_inc", 1'b0, opcodes::PcInc, 8'h00, 1'b1, 16'h1111, 1'b0, 8'h41, 16'h7777, 1'b0, 8'h41, 1'b1);
      step("fault_ign_jmp", 1'b0, opcodes::PcJmp, 8'h22, 1'b1, 16'h1111, 1'b0, 8'h41, 16'h7777, 1'b0, 8'h41, 1'b1);
      step("fault_reset", 1'b1, opcodes::PcWait, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      step("fetch_2222", 1'b0, opcodes::PcWait, 8'h00, 1'b1, 16'h2222, 1'b0, 8'h00, 16'h2222, 1'b1, 8'h00, 1'b0);
      step("jmp_22", 1'b0, opcodes::PcJmp, 8'h22, 1'b0, 16'h0000, 1'b1, 8'h22, 16'h2222, 1'b0, 8'h22, 1'b0);
      step("reset_vs_ack", 1'b1, opcodes::PcWait, 8'h00, 1'b1, 16'h3333, 1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      step("after_release", 1'b0, opcodes::PcWait, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      done = 1'b1;
      repeat (3) @(negedge Clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
